msk_sbox_bt_sched: RTL

- Sequencing controller for the two-module masked SKINNY S-box datapath with Borrowed-Time (BT) randomness pre-accumulation.
- Accepts one masked byte operation at a time via valid/ready.
- Drives the per-cycle operand mux selects and output-register enables (en2..en5) for a fixed 6-cycle schedule.
- Issues the BT clear pulse after each result is consumed, and blocks new work until the randomness accumulator has refilled.

---
 rtl/msk_sbox_bt_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/msk_sbox_bt_sched.sv
// msk_sbox_bt_sched
// Sequencing controller for the two-module masked SKINNY S-box datapath with
// Borrowed-Time (BT) randomness pre-accumulation. One masked byte operation is
// accepted at a time. The operation then runs a fixed 6-cycle schedule (C0..C5)
// that drives the operand mux selects and the output-register enables. The
// result is held in DONE until it is consumed. A single BT clear pulse follows
// (CLR), and new work is blocked until the randomness accumulator has refilled.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready depends only on registered state, never on in_valid.
// out_valid, once high, stays high until out_ready (or abort) is seen.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid/in_ready    operation request handshake
//   out_valid/out_ready  result handshake
//   abort          cancel the in-flight operation (C0..C5, DONE)
//   sel_o[11:0]    {sel2x2,sel1x2,sel2b2,sel1b2,sel2a2,sel1a2,
//                   sel2x1,sel1x1,sel2b1,sel1b1,sel2a1,sel1a1}
//   en2_o..en5_o   output-register enables (C1..C4 respectively)
//   clear_o        BT clear request, one cycle per clear event
//   rnd_en_o       fresh AND randomness must be valid this cycle
//   busy_o         state is not IDLE
//   state_o        current FSM state (debug visibility)
module msk_sbox_bt_sched #(
  parameter int          FILL_CYCLES = 10,
  parameter logic [71:0] SEL_SCHED   = 72'hF0F_0F0_FFF_AAA_555_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        abort,
  output logic [11:0] sel_o,
  output logic        en2_o,
  output logic        en3_o,
  output logic        en4_o,
  output logic        en5_o,
  output logic        clear_o,
  output logic        rnd_en_o,
  output logic        busy_o,
  output logic [3:0]  state_o
);

  localparam int CNT_W = $clog2(FILL_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_C0   = 4'd1,
    S_C1   = 4'd2,
    S_C2   = 4'd3,
    S_C3   = 4'd4,
    S_C4   = 4'd5,
    S_C5   = 4'd6,
    S_DONE = 4'd7,
    S_CLR  = 4'd8
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   fill_cnt, fill_next;
  logic               rnd_full;

  logic [11:0] sel_d;
  logic        en2_d, en3_d, en4_d, en5_d, clear_d, rnd_en_d, out_valid_d, busy_d;

  assign rnd_full = (fill_cnt == CNT_W'(FILL_CYCLES));
  assign in_ready = (state == S_IDLE) && rnd_full;
  assign state_o  = state;

  // Next-state logic. abort wins over the schedule in C0..C5 and DONE; in DONE
  // abort and out_ready both lead to the same single CLR visit.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid && in_ready) state_next = S_C0;
      S_C0:   state_next = abort ? S_CLR : S_C1;
      S_C1:   state_next = abort ? S_CLR : S_C2;
      S_C2:   state_next = abort ? S_CLR : S_C3;
      S_C3:   state_next = abort ? S_CLR : S_C4;
      S_C4:   state_next = abort ? S_CLR : S_C5;
      S_C5:   state_next = abort ? S_CLR : S_DONE;
      S_DONE: if (out_ready || abort) state_next = S_CLR;
      S_CLR:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The counter is zero during the clear cycle itself, so refill overlaps the
  // CLR cycle and the accept-to-accept spacing is 8 + FILL_CYCLES.
  always_comb begin
    if (state_next == S_CLR)  fill_next = '0;
    else if (rnd_full)        fill_next = fill_cnt;
    else                      fill_next = fill_cnt + 1'b1;
  end

  // Outputs are decoded from the next state and registered, so every output
  // changes cleanly on the clock edge together with the state.
  always_comb begin
    sel_d       = 12'h000;
    en2_d       = 1'b0;
    en3_d       = 1'b0;
    en4_d       = 1'b0;
    en5_d       = 1'b0;
    clear_d     = 1'b0;
    rnd_en_d    = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = (state_next != S_IDLE);
    case (state_next)
      S_C0: begin sel_d = SEL_SCHED[11:0];  rnd_en_d = 1'b1; end
      S_C1: begin sel_d = SEL_SCHED[23:12]; rnd_en_d = 1'b1; en2_d = 1'b1; end
      S_C2: begin sel_d = SEL_SCHED[35:24]; rnd_en_d = 1'b1; en3_d = 1'b1; end
      S_C3: begin sel_d = SEL_SCHED[47:36]; rnd_en_d = 1'b1; en4_d = 1'b1; end
      S_C4: begin sel_d = SEL_SCHED[59:48]; rnd_en_d = 1'b1; en5_d = 1'b1; end
      S_C5: begin sel_d = SEL_SCHED[71:60]; rnd_en_d = 1'b1; end
      S_DONE: out_valid_d = 1'b1;
      S_CLR:  clear_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fill_cnt  <= '0;
      sel_o     <= 12'h000;
      en2_o     <= 1'b0;
      en3_o     <= 1'b0;
      en4_o     <= 1'b0;
      en5_o     <= 1'b0;
      clear_o   <= 1'b0;
      rnd_en_o  <= 1'b0;
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_next;
      fill_cnt  <= fill_next;
      sel_o     <= sel_d;
      en2_o     <= en2_d;
      en3_o     <= en3_d;
      en4_o     <= en4_d;
      en5_o     <= en5_d;
      clear_o   <= clear_d;
      rnd_en_o  <= rnd_en_d;
      out_valid <= out_valid_d;
      busy_o    <= busy_d;
    end
  end

endmodule
